hier_rsp_collector: RTL

- Upward (child-to-parent) return path for one node of the generated instance hierarchy. Each node fans out to NUM_CHILDREN child instances.
- Merges per-child response streams into one upstream stream. Uses round-robin arbitration and a small FIFO.
- Tags each beat with its child index. Pulses a completion flag once every child has delivered its last beat.
- Chains node to node toward the root module.

---
 rtl/hier_rsp_collector_pkg.sv | 13 +
 rtl/hier_rsp_collector_if.sv | 30 +++
 rtl/hier_rsp_collector_fifo.sv | 48 ++++
 rtl/hier_rsp_collector.sv | 84 ++++++++
 4 files changed

// File: rtl/hier_rsp_collector_pkg.sv
// hier_rsp_pkg: shared beat layout, default sizes and completion-state encoding.
package hier_rsp_pkg;
  localparam int RSP_NUM_CHILDREN = 5;
  localparam int RSP_DATA_W = 16;
  localparam int RSP_FIFO_DEPTH = 4;
  localparam int RSP_IDX_W = $clog2(RSP_NUM_CHILDREN);
  typedef struct packed {
    logic                 last;
    logic [RSP_IDX_W-1:0] src;
    logic [RSP_DATA_W-1:0] data;
  } rsp_beat_t;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} collect_state_e;
endpackage

// File: rtl/hier_rsp_collector_if.sv
// hier_rsp_collector_if: child-side and upstream-side signals of one collector node.
interface hier_rsp_collector_if
  import hier_rsp_pkg::*;
#(
  parameter int NUM_CHILDREN = RSP_NUM_CHILDREN,
  parameter int DATA_W = RSP_DATA_W,
  parameter int FIFO_DEPTH = RSP_FIFO_DEPTH
);
  localparam int IDX_W = $clog2(NUM_CHILDREN);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  logic [NUM_CHILDREN-1:0]        child_valid;
  logic [NUM_CHILDREN-1:0]        child_last;
  logic [NUM_CHILDREN*DATA_W-1:0] child_data;
  logic [NUM_CHILDREN-1:0]        child_ready;
  logic                           up_valid;
  logic                           up_ready;
  logic [DATA_W-1:0]              up_data;
  logic [IDX_W-1:0]               up_src;
  logic                           up_last;
  logic                           all_done;
  logic [LVL_W-1:0]               fifo_level;
  modport master (
    output child_valid, child_last, child_data, up_ready,
    input  child_ready, up_valid, up_data, up_src, up_last, all_done, fifo_level
  );
  modport slave (
    input  child_valid, child_last, child_data, up_ready,
    output child_ready, up_valid, up_data, up_src, up_last, all_done, fifo_level
  );
endinterface

// File: rtl/hier_rsp_collector_fifo.sv
// hier_rsp_fifo: synchronous FIFO with registered storage; head readable straight from the array.
module hier_rsp_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [W-1:0]           din,
  output logic [W-1:0]           dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q, level_d;
  logic do_push, do_pop;
  assign full = level_q == (AW+1)'(DEPTH);
  assign empty = level_q == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem_q[rd_ptr_q];
  assign level = level_q;
  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    mem_d = mem_q;
    if (do_push) mem_d[wr_ptr_q] = din;
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    level_d = level_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q <= level_d;
    end
  end
endmodule

// File: rtl/hier_rsp_collector.sv
// hier_rsp_collector: round-robin merge of child response streams into one tagged upstream stream,
// with a one-cycle all_done pulse once every child has delivered its last beat.
module hier_rsp_collector
  import hier_rsp_pkg::*;
#(
  parameter int NUM_CHILDREN = RSP_NUM_CHILDREN,
  parameter int DATA_W = RSP_DATA_W,
  parameter int FIFO_DEPTH = RSP_FIFO_DEPTH
) (
  input logic clk,
  input logic rst_n,
  hier_rsp_collector_if.slave b
);
  localparam int IDX_W = $clog2(NUM_CHILDREN);
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  typedef struct packed {
    logic              last;
    logic [IDX_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } beat_t;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, grant_idx;
  logic [NUM_CHILDREN-1:0] done_mask_q, done_mask_d;
  collect_state_e state_q, state_d;
  logic grant, full, empty, pop;
  beat_t push_beat, head;
  logic [LVL_W-1:0] level;
  int idx;
  // Grant is withheld when full, even if a pop frees a slot this same cycle.
  always_comb begin
    grant = 1'b0;
    grant_idx = '0;
    idx = 0;
    for (int k = 0; k < NUM_CHILDREN; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_CHILDREN;
      if (!grant && rst_n && !full && b.child_valid[idx]) begin
        grant = 1'b1;
        grant_idx = IDX_W'(idx);
      end
    end
  end
  assign rr_ptr_d = grant ? ((grant_idx == IDX_W'(NUM_CHILDREN-1)) ? '0 : grant_idx + 1'b1) : rr_ptr_q;
  assign b.child_ready = grant ? {{(NUM_CHILDREN-1){1'b0}}, 1'b1} << grant_idx : '0;
  assign push_beat = {b.child_last[grant_idx], grant_idx, b.child_data[grant_idx*DATA_W +: DATA_W]};
  assign pop = !empty && b.up_ready;
  assign b.up_valid = !empty;
  assign {b.up_last, b.up_src, b.up_data} = empty ? '0 : head;
  assign b.fifo_level = level;
  hier_rsp_fifo #(.W($bits(beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(grant),
    .pop(pop),
    .din(push_beat),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(level)
  );
  // A last popped in the DONE cycle already belongs to the next round.
  always_comb begin
    done_mask_d = (state_q == DONE) ? '0 : done_mask_q;
    if (pop && head.last) done_mask_d[head.src] = 1'b1;
  end
  always_comb begin
    state_d = state_q;
    if (state_q == DONE) state_d = IDLE;
    else if (&done_mask_d) state_d = DONE;
    else if (grant || !empty) state_d = COLLECT;
  end
  always_comb begin
    b.all_done = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_mask_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q <= state_d;
      done_mask_q <= done_mask_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end
endmodule
